uart_rx_fifo: RTL

//   Parametrised UART receiver with runtime-selectable parity and 1/2 stop bits.

---
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, 3-sample majority vote per bit, runtime parity/stop config,
// per-frame error flags, frames buffered in a show-ahead FIFO with a sticky overrun flag.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_two_stop,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_break,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam logic [CW-1:0] SMP_A = CW'(CPB/2 - 1);
  localparam logic [CW-1:0] SMP_B = CW'(CPB/2);
  localparam logic [CW-1:0] SMP_V = CW'(CPB/2 + 1);
  localparam logic [CW-1:0] LAST  = CW'(CPB - 1);

  if (CPB < 8) begin : g_cpb_chk
    $error("uart_rx_fifo: CLK_HZ/BIT_RATE must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic                 brk;
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;

  logic [1:0]           sync;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic                 s_a, s_b, vote, at_vote, at_last;
  logic [BW-1:0]        bidx;
  logic                 stop_idx, armed;
  logic                 par_en_q, par_odd_q, two_stop_q;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, ferr_acc, ferr_fin;
  logic                 push;
  entry_t               din;

  assign rxs     = sync[1];
  assign at_vote = cnt == SMP_V;
  assign at_last = cnt == LAST;
  assign vote    = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    ferr_fin = ferr_acc | ~vote;
    din.data = shreg;
    din.perr = par_en_q & ((^shreg ^ par_bit) != par_odd_q);
    din.ferr = ferr_fin;
    din.brk  = ferr_fin & (shreg == '0) & ~par_bit;
    if (!uart_rx_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (armed && !rxs) state_n = START;
        START:  if (at_vote && vote) state_n = IDLE;
                else if (at_last) state_n = DATA;
        DATA:   if (at_last && bidx == BW'(DATA_BITS - 1)) state_n = par_en_q ? PARITY : STOP;
        PARITY: if (at_last) state_n = STOP;
        STOP:   if (at_vote && stop_idx == two_stop_q) begin
                  push    = 1'b1;
                  state_n = IDLE;
                end
        default: state_n = IDLE;
      endcase
    end
  end

  // IDLE counts as sample 0 of the start bit, so START resumes at 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync       <= 2'b11;
      cnt        <= '0;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
      bidx       <= '0;
      stop_idx   <= 1'b0;
      armed      <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
    end else begin
      if (uart_rx_en) sync <= {sync[0], uart_rxd};
      if (state == IDLE) cnt <= CW'(1);
      else               cnt <= at_last ? '0 : cnt + CW'(1);
      if (cnt == SMP_A) s_a <= rxs;
      if (cnt == SMP_B) s_b <= rxs;
      // A completed frame must see the line high again before re-arming (break handling).
      if (!uart_rx_en || push)      armed <= 1'b0;
      else if (state == IDLE && rxs) armed <= 1'b1;
      if (state == IDLE && state_n == START) begin
        par_en_q   <= cfg_parity_en;
        par_odd_q  <= cfg_parity_odd;
        two_stop_q <= cfg_two_stop;
        bidx       <= '0;
        stop_idx   <= 1'b0;
        par_bit    <= 1'b0;
        ferr_acc   <= 1'b0;
      end
      if (state == DATA) begin
        if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
        if (at_last) bidx  <= bidx + BW'(1);
      end
      if (state == PARITY && at_vote) par_bit <= vote;
      if (state == STOP) begin
        if (at_vote && !vote) ferr_acc <= 1'b1;
        if (at_last)          stop_idx <= 1'b1;
      end
    end
  end

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic            full, do_pop, do_push;

  assign full    = level == LW'(FIFO_DEPTH);
  assign do_pop  = rx_valid & rx_ready;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (resetn && do_push) mem[wr_ptr] <= din;
  end

  // Head is a register so it holds its last value while empty and resets to 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      head       <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
      if (do_push && (level == '0 || (do_pop && level == LW'(1)))) head <= din;
      else if (do_pop && level > LW'(1))                          head <= mem[rd_ptr + PW'(1)];
      if (push && full && !do_pop) rx_overrun <= 1'b1;
      else if (overrun_clr)        rx_overrun <= 1'b0;
    end
  end

  assign rx_valid   = level != '0;
  assign fifo_level = level;
  assign rx_data    = head.data;
  assign rx_perr    = head.perr;
  assign rx_ferr    = head.ferr;
  assign rx_break   = head.brk;
endmodule
